// File: rtl/bus_arb_pkg.sv
// rtl/bus_arb_pkg.sv - shared state encoding and default widths for the two-master bus arbiter
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    G0   = 2'b01,
    G1   = 2'b10
  } arb_state_t;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 64;

endpackage

// File: rtl/bus_arbiter_2m_if.sv
// rtl/bus_arbiter_2m_if.sv - master-side and bus-side signal bundle of the two-master arbiter
interface bus_arbiter_2m_if #(
  parameter int ADDR_W = bus_arb_pkg::DEF_ADDR_W,
  parameter int DATA_W = bus_arb_pkg::DEF_DATA_W
);
  logic              m0_req;
  logic              m0_wr;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_dout;
  logic              m0_grant;
  logic [DATA_W-1:0] m0_din;

  logic              m1_req;
  logic              m1_wr;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_dout;
  logic              m1_grant;
  logic [DATA_W-1:0] m1_din;

  logic              b_req;
  logic              b_wr;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_dout;
  logic [DATA_W-1:0] b_din;

  // Arbiter side.
  modport slave (
    input  m0_req, m0_wr, m0_addr, m0_dout,
    input  m1_req, m1_wr, m1_addr, m1_dout,
    input  b_din,
    output m0_grant, m0_din, m1_grant, m1_din,
    output b_req, b_wr, b_addr, b_dout
  );

  // Masters plus the bus model, as seen from outside the arbiter.
  modport master (
    output m0_req, m0_wr, m0_addr, m0_dout,
    output m1_req, m1_wr, m1_addr, m1_dout,
    output b_din,
    input  m0_grant, m0_din, m1_grant, m1_din,
    input  b_req, b_wr, b_addr, b_dout
  );
endinterface

// File: rtl/bus_master_mux.sv
// rtl/bus_master_mux.sv - selects the granted master's wr/addr/dout onto the bus, zero when idle
module bus_master_mux
  import bus_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  arb_state_t        state,
  input  logic              m0_wr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_dout,
  input  logic              m1_wr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_dout,
  output logic              b_wr,
  output logic [ADDR_W-1:0] b_addr,
  output logic [DATA_W-1:0] b_dout
);

  always_comb begin
    b_wr   = 1'b0;
    b_addr = '0;
    b_dout = '0;
    case (state)
      G0: begin
        b_wr   = m0_wr;
        b_addr = m0_addr;
        b_dout = m0_dout;
      end
      G1: begin
        b_wr   = m1_wr;
        b_addr = m1_addr;
        b_dout = m1_dout;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/bus_arbiter_2m.sv
// rtl/bus_arbiter_2m.sv - two-master arbiter with bounded tenure; BUS_ARB_RR_EN selects round-robin tie-break
module bus_arbiter_2m
  import bus_arb_pkg::*;
#(
  parameter int MAX_TENURE = 16,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W
) (
  input logic             clk,
  input logic             reset_n,
  bus_arbiter_2m_if.slave bus
);

  localparam int TW = $clog2(MAX_TENURE);
  localparam logic [TW-1:0] TEN_LAST = TW'(MAX_TENURE - 1);

  arb_state_t    state, state_next;
  logic [TW-1:0] tenure, tenure_next;
  arb_state_t    tie_pick;

`ifdef BUS_ARB_RR_EN
  // 1 means master 1 held the bus most recently.
  logic last_grant;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_grant <= 1'b1;
    end else if (state_next == G0 && state != G0) begin
      last_grant <= 1'b0;
    end else if (state_next == G1 && state != G1) begin
      last_grant <= 1'b1;
    end
  end

  assign tie_pick = last_grant ? G0 : G1;
`else
  assign tie_pick = G0;
`endif

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.m0_req && bus.m1_req) state_next = tie_pick;
        else if (bus.m0_req)          state_next = G0;
        else if (bus.m1_req)          state_next = G1;
      end
      G0: begin
        if (!bus.m0_req)                          state_next = bus.m1_req ? G1 : IDLE;
        else if (bus.m1_req && tenure == TEN_LAST) state_next = G1;
      end
      G1: begin
        if (!bus.m1_req)                          state_next = bus.m0_req ? G0 : IDLE;
        else if (bus.m0_req && tenure == TEN_LAST) state_next = G0;
      end
      default: state_next = IDLE;
    endcase
  end

  // Tenure only advances while the other master is actually waiting.
  always_comb begin
    tenure_next = tenure;
    if (state_next != state || state_next == IDLE) begin
      tenure_next = '0;
    end else if ((state == G0 && bus.m1_req) || (state == G1 && bus.m0_req)) begin
      tenure_next = tenure + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= IDLE;
      tenure <= '0;
    end else begin
      state  <= state_next;
      tenure <= tenure_next;
    end
  end

  assign bus.m0_grant = (state == G0);
  assign bus.m1_grant = (state == G1);
  assign bus.b_req    = (state != IDLE);
  assign bus.m0_din   = (state == G0) ? bus.b_din : '0;
  assign bus.m1_din   = (state == G1) ? bus.b_din : '0;

  bus_master_mux #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_mux (
    .state  (state),
    .m0_wr  (bus.m0_wr),
    .m0_addr(bus.m0_addr),
    .m0_dout(bus.m0_dout),
    .m1_wr  (bus.m1_wr),
    .m1_addr(bus.m1_addr),
    .m1_dout(bus.m1_dout),
    .b_wr   (bus.b_wr),
    .b_addr (bus.b_addr),
    .b_dout (bus.b_dout)
  );

endmodule

// File: tb/tb_bus_arbiter_2m.sv
// tb/tb_bus_arbiter_2m.sv - directed plus randomized checks of bus_arbiter_2m against an ownership model
module tb_bus_arbiter_2m;

  localparam int MAXT = 4;
`ifdef BUS_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  // Model: owner 0 = nobody, 1 = master 0, 2 = master 1.
  int exp_owner = 0;
  int exp_run   = 0;
  int exp_last  = 1;

  always #5 clk = ~clk;

  bus_arbiter_2m_if #(.ADDR_W(16), .DATA_W(64)) bus_if ();

  bus_arbiter_2m #(.MAX_TENURE(MAXT), .ADDR_W(16), .DATA_W(64)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus_if)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic rst, input logic r0, input logic r1);
    int prev;
    int other;
    logic own_req, oth_req;
    prev = exp_owner;
    if (!rst) begin
      exp_owner = 0;
      exp_run   = 0;
      exp_last  = 1;
      return;
    end
    if (exp_owner == 0) begin
      if (r0 && r1)  exp_owner = RR ? ((exp_last == 1) ? 1 : 2) : 1;
      else if (r0)   exp_owner = 1;
      else if (r1)   exp_owner = 2;
    end else begin
      other   = (exp_owner == 1) ? 2 : 1;
      own_req = (exp_owner == 1) ? r0 : r1;
      oth_req = (exp_owner == 1) ? r1 : r0;
      if (!own_req) begin
        exp_owner = oth_req ? other : 0;
      end else if (oth_req) begin
        exp_run++;
        if (exp_run == MAXT) exp_owner = other;
      end
    end
    if (exp_owner != prev) begin
      exp_run = 0;
      if (exp_owner != 0) exp_last = exp_owner - 1;
    end
  endtask

  task automatic check_all();
    logic        e_wr;
    logic [15:0] e_addr;
    logic [63:0] e_dout;
    e_wr   = (exp_owner == 1) ? bus_if.m0_wr   : (exp_owner == 2) ? bus_if.m1_wr   : 1'b0;
    e_addr = (exp_owner == 1) ? bus_if.m0_addr : (exp_owner == 2) ? bus_if.m1_addr : 16'h0;
    e_dout = (exp_owner == 1) ? bus_if.m0_dout : (exp_owner == 2) ? bus_if.m1_dout : 64'h0;
    check("m0_grant", 64'(bus_if.m0_grant), 64'(exp_owner == 1));
    check("m1_grant", 64'(bus_if.m1_grant), 64'(exp_owner == 2));
    check("both_grant", 64'(bus_if.m0_grant & bus_if.m1_grant), 64'h0);
    check("b_req", 64'(bus_if.b_req), 64'(exp_owner != 0));
    check("b_wr", 64'(bus_if.b_wr), 64'(e_wr));
    check("b_addr", 64'(bus_if.b_addr), 64'(e_addr));
    check("b_dout", bus_if.b_dout, e_dout);
    check("m0_din", bus_if.m0_din, (exp_owner == 1) ? bus_if.b_din : 64'h0);
    check("m1_din", bus_if.m1_din, (exp_owner == 2) ? bus_if.b_din : 64'h0);
  endtask

  task automatic drive(input logic r0, input logic r1);
    bus_if.m0_req  = r0;
    bus_if.m1_req  = r1;
    bus_if.m0_wr   = 1'($urandom);
    bus_if.m1_wr   = 1'($urandom);
    bus_if.m0_addr = 16'($urandom);
    bus_if.m1_addr = 16'($urandom);
    bus_if.m0_dout = {$urandom, $urandom};
    bus_if.m1_dout = {$urandom, $urandom};
    bus_if.b_din   = {$urandom, $urandom};
  endtask

  // Inputs are set just after a falling edge; outputs are checked on the next falling edge.
  task automatic cycle();
    @(posedge clk);
    model_edge(reset_n, bus_if.m0_req, bus_if.m1_req);
    @(negedge clk);
    check_all();
  endtask

  task automatic run(input logic r0, input logic r1, input int n);
    for (int i = 0; i < n; i++) begin
      drive(r0, r1);
      cycle();
    end
  endtask

  initial begin
    reset_n = 1'b0;
    drive(1'b1, 1'b1);

    // Reset with both masters requesting.
    cycle();
    drive(1'b1, 1'b1);
    cycle();
    reset_n = 1'b1;
    drive(1'b1, 1'b1);
    cycle();
    check("first_grant_m0", 64'(bus_if.m0_grant), 64'h1);

    // Single master 1 with a fixed write address.
    run(1'b0, 1'b0, 1);
    for (int i = 0; i < 40; i++) begin
      drive(1'b0, 1'b1);
      bus_if.m1_addr = 16'h7010;
      bus_if.m1_wr   = 1'b1;
      cycle();
      check("single_m1_grant", 64'(bus_if.m1_grant), 64'h1);
      check("single_b_addr", 64'(bus_if.b_addr), 64'h7010);
    end

    // Continuous contention: alternating tenures of MAXT cycles.
    run(1'b0, 1'b0, 1);
    run(1'b1, 1'b1, 3 * MAXT + 2);

    // Direct handover without an idle cycle.
    run(1'b0, 1'b0, 1);
    run(1'b1, 1'b0, 3);
    drive(1'b0, 1'b1);
    cycle();
    check("handover_m1", 64'(bus_if.m1_grant), 64'h1);
    check("handover_addr", 64'(bus_if.b_addr), 64'(bus_if.m1_addr));

    // Ties from idle after master 1 was last granted.
    run(1'b0, 1'b1, 2);
    run(1'b0, 1'b0, 1);
    run(1'b1, 1'b1, 1);
    check("tie1_m0", 64'(bus_if.m0_grant), 64'h1);
    run(1'b0, 1'b0, 1);
    run(1'b1, 1'b1, 1);
    check("tie2_m1", 64'(bus_if.m1_grant), 64'(RR));

    // Reset in the middle of a contended master-1 tenure.
    run(1'b0, 1'b0, 1);
    run(1'b0, 1'b1, 1);
    run(1'b1, 1'b1, 2);
    reset_n = 1'b0;
    drive(1'b1, 1'b1);
    cycle();
    check("midrst_m1_grant", 64'(bus_if.m1_grant), 64'h0);
    check("midrst_b_req", 64'(bus_if.b_req), 64'h0);
    check("midrst_b_addr", 64'(bus_if.b_addr), 64'h0);
    reset_n = 1'b1;
    run(1'b1, 1'b1, 2 * MAXT + 1);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      reset_n = ($urandom_range(0, 99) != 0);
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_2m.md
# bus_arbiter_2m

Two-master arbiter and request multiplexer that sits in front of the single-master bus port. It shares that port between master 0 (CPU/testbench) and master 1 (DMA), grants exactly one master at a time, and forwards the granted master's write/address/data onto the bus. A tenure counter bounds how long one master may hold the bus while the other is waiting.

## Interface
- MAX_TENURE, 16, maximum consecutive grant cycles while the other master is requesting (≥2)
- ADDR_W, 16, address width
- DATA_W, 64, data width

- clk  in  1  clock, all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- m0_req / m1_req  in  1  bus request from master 0 / 1
- m0_wr / m1_wr  in  1  write enable from master 0 / 1
- m0_addr / m1_addr  in  ADDR_W  address from master 0 / 1
- m0_dout / m1_dout  in  DATA_W  write data from master 0 / 1
- m0_grant / m1_grant  out  1  registered grant to master 0 / 1
- m0_din / m1_din  out  DATA_W  read data to master 0 / 1 (b_din when granted, else 0)
- b_req  out  1  request to the bus (high in any grant state)
- b_wr  out  1  forwarded write enable
- b_addr  out  ADDR_W  forwarded address
- b_dout  out  DATA_W  forwarded write data
- b_din  in  DATA_W  read data returned by the bus

## Operation
- FSM states: IDLE, G0, G1. Outputs m0_grant = (state==G0) and m1_grant = (state==G1). Grant outputs are decoded directly from the state register, so they are glitch-free.
- IDLE:
  - Only m0_req → G0.
  - Only m1_req → G1.
  - Both requesting → priority rule (see Configuration).
  - Neither requesting → stay in IDLE.
- G0 (G1 is symmetric):
  - m0_req low and m1_req high → G1 directly, with no IDLE bubble.
  - m0_req low and m1_req low → IDLE.
  - m0_req high, m1_req high, and tenure == MAX_TENURE-1 → G1 (forced handover).
  - Otherwise stay in G0.
- Tenure counter:
  - Width is $clog2(MAX_TENURE).
  - Clears on any state change and in IDLE.
  - Increments each cycle in G0/G1 while the other master is requesting.
  - Holds while the other master is idle, so an uncontended master keeps the bus indefinitely.
- Forwarding is combinational from the state register:
  - In G0, b_wr/b_addr/b_dout take the m0_* values.
  - In G1, they take the m1_* values.
  - In IDLE, b_wr, b_addr and b_dout are all 0.
- Read data: b_din is steered to the granted master's din. The non-granted master's din is forced to 0.

## Timing
- Reset (reset_n low at a rising edge):
  - State → IDLE, tenure → 0, last-grant pointer → master 1.
  - All outputs 0: m0_grant, m1_grant, b_req, b_wr, b_addr, b_dout, m0_din, m1_din.
- Reset has priority over all transitions. Asserting it mid-tenure drops the grant at the same edge.
- Latency:
  - A request sampled at edge N yields grant high after edge N.
  - A request drop sampled at edge N yields grant low after edge N.
- Handover G0→G1 takes one edge. There is never a cycle with both grants high.
- Forced handover:
  - With both masters requesting continuously, each master holds the bus for exactly MAX_TENURE cycles.
  - Grants then alternate G0→G1→G0.
- Masters must hold wr/addr/dout stable while granted. The arbiter does not register them.

## Configuration
- BUS_ARB_RR_EN defined:
  - Round-robin tie-break in IDLE: the master not granted most recently wins.
  - The last-grant pointer updates on every entry into G0/G1.
- BUS_ARB_RR_EN undefined:
  - Fixed priority: master 0 always wins a tie in IDLE.
  - No pointer register is built.
- Tenure-based handover from G0/G1 is identical in both builds.

## Structure
- Package bus_arb_pkg holds:
  - the state typedef (IDLE=2'b00, G0=2'b01, G1=2'b10);
  - the default ADDR_W/DATA_W constants.
- Sub-module bus_master_mux: a 2-to-1 selector for {wr, addr, dout} driven by the state, outputting 0 in IDLE. It is instantiated once for the bus-side signals.
- Din steering and the FSM/counter live in the top level.

## Test plan
- Reset: hold reset_n low 2 cycles with both requests high → all outputs 0. First grant appears one edge after reset_n rises: m0 in the fixed build, m0 in the RR build (pointer = 1).
- Single master: m1_req high for 40 cycles with m1_addr=16'h7010, wr=1 → m1_grant high after 1 edge and stays high all 40 cycles; b_addr=16'h7010; m0_din=0 throughout.
- Contention: both requests high continuously, MAX_TENURE=4 → grant pattern G0×4, G1×4, G0×4, …; never both grants high.
- Direct handover: G0 active, m0_req drops while m1_req is high → m1_grant rises at the same edge m0_grant falls; no IDLE cycle; b_addr switches to m1_addr.
- Tie from IDLE with BUS_ARB_RR_EN: sequence where m1 was last granted, then both request together → m0 granted; repeat → m1 granted. Without the macro → m0 granted both times.
- Mid-tenure reset: during G1 with tenure=2, pull reset_n low → after that edge m1_grant=0, b_req=0, b_addr=0, and the counter restarts from 0 after release.
